// File: rtl/if_fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_ctrl_pkg : shared constants and types for the fetch front end|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int          INST_W   = 32;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_EXCP = 2'd2,
    REDIR_ERTN = 2'd3
  } redir_src_e;

  // Exception beats ertn, ertn beats branch.
  function automatic redir_src_e redir_select(input logic excp, input logic ertn, input logic br);
    if (excp) return REDIR_EXCP;
    if (ertn) return REDIR_ERTN;
    if (br)   return REDIR_BR;
    return REDIR_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_ctrl_fetch_pc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_fifo : synchronous FIFO holding PCs of live fetch requests  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_pc_fifo
  import if_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = INST_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & !full & !clear;
    do_pop   = pop & !empty & !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_ctrl : fetch PC sequencer with in-order outstanding requests |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = if_fetch_ctrl_pkg::RESET_PC,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          CNT_W           = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  input  logic              excp_flush,
  input  logic [31:0]       excp_entry,
  input  logic              ertn_flush,
  input  logic [31:0]       era,
  output logic              req_valid,
  output logic [31:0]       req_addr,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_inst,
  output logic              resp_ready,
  output logic              ib_valid,
  output logic [INST_W-1:0] ib_inst,
  output logic [31:0]       ib_pc,
  input  logic              ib_ready
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              ib_valid_q, ib_valid_d;
  logic [INST_W-1:0] ib_inst_q, ib_inst_d;
  logic [31:0]       ib_pc_q, ib_pc_d;

  redir_src_e        redir_src;
  logic              redir;
  logic [31:0]       redir_target;
  logic              issue;
  logic              resp_acc;
  logic              resp_live;
  logic [31:0]       fifo_head;
  logic              fifo_empty;
  logic              fifo_full;

  fetch_pc_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (32)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue),
    .push_data (pc_q),
    .pop       (resp_live),
    .clear     (redir),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    redir_src = redir_select(excp_flush, ertn_flush, flush);
    redir     = (redir_src != REDIR_NONE);
    case (redir_src)
      REDIR_EXCP: redir_target = {excp_entry[31:2], 2'b00};
      REDIR_ERTN: redir_target = {era[31:2], 2'b00};
      default:    redir_target = {flush_pc[31:2], 2'b00};
    endcase

    req_valid  = !reset & !redir & (out_cnt_q < MAX_CNT) & !fifo_full;
    req_addr   = pc_q;
    resp_ready = (drop_cnt_q != '0) | !ib_valid_q | ib_ready;
    issue      = req_valid & req_ready;
    resp_acc   = resp_valid & resp_ready;
    // A response landing in a redirect cycle is stale even if drop_cnt is zero.
    resp_live  = resp_acc & (drop_cnt_q == '0) & !redir & !fifo_empty;

    pc_d = pc_q;
    if (redir)      pc_d = redir_target;
    else if (issue) pc_d = pc_q + 32'd4;

    out_cnt_d = out_cnt_q;
    if (issue && !resp_acc)      out_cnt_d = out_cnt_q + CNT_ONE;
    else if (!issue && resp_acc) out_cnt_d = out_cnt_q - CNT_ONE;

    drop_cnt_d = drop_cnt_q;
    if (redir)                               drop_cnt_d = resp_acc ? out_cnt_q - CNT_ONE : out_cnt_q;
    else if (resp_acc && drop_cnt_q != '0)   drop_cnt_d = drop_cnt_q - CNT_ONE;

    ib_valid_d = ib_valid_q;
    ib_inst_d  = ib_inst_q;
    ib_pc_d    = ib_pc_q;
    if (redir) begin
      ib_valid_d = 1'b0;
    end else if (resp_live) begin
      ib_valid_d = 1'b1;
      ib_inst_d  = resp_inst;
      ib_pc_d    = fifo_head;
    end else if (ib_valid_q && ib_ready) begin
      ib_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ib_valid_q <= 1'b0;
      ib_inst_q  <= '0;
      ib_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ib_valid_q <= ib_valid_d;
      ib_inst_q  <= ib_inst_d;
      ib_pc_q    <= ib_pc_d;
    end
  end

  assign ib_valid = ib_valid_q;
  assign ib_inst  = ib_inst_q;
  assign ib_pc    = ib_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_fetch_ctrl : directed self-checking bench for if_fetch_ctrl    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_if_fetch_ctrl;

  localparam logic [31:0] MAGIC = 32'hdead_0000;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        excp_flush;
  logic [31:0] excp_entry;
  logic        ertn_flush;
  logic [31:0] era;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        resp_ready;
  logic        ib_valid;
  logic [31:0] ib_inst;
  logic [31:0] ib_pc;
  logic        ib_ready;

  if_fetch_ctrl #(
    .RESET_PC        (32'h1c00_0000),
    .MAX_OUTSTANDING (2),
    .CNT_W           (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .excp_flush (excp_flush),
    .excp_entry (excp_entry),
    .ertn_flush (ertn_flush),
    .era        (era),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .resp_ready (resp_ready),
    .ib_valid   (ib_valid),
    .ib_inst    (ib_inst),
    .ib_pc      (ib_pc),
    .ib_ready   (ib_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  int          n_iss = 0;
  bit          hold  = 1'b0;
  logic [31:0] mem_q[$];
  logic [31:0] dpc[$];
  logic [31:0] dinst[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: one-cycle latency, in-order, held stable until accepted.
  task automatic drive_resp();
    resp_valid = !hold && (mem_q.size() != 0);
    resp_inst  = (mem_q.size() != 0) ? (mem_q[0] ^ MAGIC) : 32'h0;
  endtask

  task automatic tick();
    bit          rh;
    bit          sh;
    logic [31:0] a;
    @(negedge clk);
    rh = req_valid && req_ready;
    sh = resp_valid && resp_ready;
    a  = req_addr;
    if (ib_valid && ib_ready) begin
      dpc.push_back(ib_pc);
      dinst.push_back(ib_inst);
    end
    @(posedge clk);
    #1;
    if (sh) void'(mem_q.pop_front());
    if (rh) begin
      mem_q.push_back(a);
      n_iss++;
    end
    drive_resp();
    #1;
  endtask

  task automatic hold_reset();
    reset      = 1'b1;
    flush      = 1'b0;
    flush_pc   = 32'h0;
    excp_flush = 1'b0;
    excp_entry = 32'h0;
    ertn_flush = 1'b0;
    era        = 32'h0;
    req_ready  = 1'b1;
    ib_ready   = 1'b1;
    hold       = 1'b0;
    mem_q.delete();
    dpc.delete();
    dinst.delete();
    n_iss = 0;
    drive_resp();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values, then streaming fetch with a 1-cycle memory
    hold_reset();
    check_eq("rst_req_valid", {31'h0, req_valid}, 32'd0);
    check_eq("rst_resp_ready", {31'h0, resp_ready}, 32'd1);
    check_eq("rst_ib_valid", {31'h0, ib_valid}, 32'd0);
    check_eq("rst_ib_pc", ib_pc, 32'h0);
    check_eq("rst_ib_inst", ib_inst, 32'h0);
    reset = 1'b0;
    #1;
    check_eq("first_req_valid", {31'h0, req_valid}, 32'd1);
    check_eq("first_req_addr", req_addr, 32'h1c00_0000);
    repeat (8) tick();
    check_eq("stream_count", 32'(dpc.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq("stream_pc", dpc[i], 32'h1c00_0000 + 32'(4 * i));
      check_eq("stream_inst", dinst[i], (32'h1c00_0000 + 32'(4 * i)) ^ MAGIC);
    end

    // Outstanding limit with withheld responses
    hold_reset();
    hold  = 1'b1;
    reset = 1'b0;
    drive_resp();
    #1;
    repeat (6) tick();
    check_eq("full_issued", 32'(n_iss), 32'd2);
    check_eq("full_req_valid", {31'h0, req_valid}, 32'd0);
    hold = 1'b0;
    drive_resp();
    #1;
    tick();
    hold = 1'b1;
    drive_resp();
    #1;
    check_eq("one_resp_ib_valid", {31'h0, ib_valid}, 32'd1);
    check_eq("one_resp_ib_pc", ib_pc, 32'h1c00_0000);
    repeat (5) tick();
    check_eq("one_more_issue", 32'(n_iss), 32'd3);

    // Branch flush with two requests in flight
    hold_reset();
    hold  = 1'b1;
    reset = 1'b0;
    drive_resp();
    #1;
    repeat (3) tick();
    flush    = 1'b1;
    flush_pc = 32'h1c00_0100;
    #1;
    check_eq("redir_blocks_req", {31'h0, req_valid}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_req_addr", req_addr, 32'h1c00_0100);
    check_eq("flush_ib_valid", {31'h0, ib_valid}, 32'd0);
    check_eq("flush_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    dpc.delete();
    dinst.delete();
    hold = 1'b0;
    drive_resp();
    #1;
    repeat (8) tick();
    check_eq("flush_deliv_count", 32'(dpc.size()), 32'd5);
    check_eq("flush_first_pc", dpc[0], 32'h1c00_0100);
    check_eq("flush_first_inst", dinst[0], 32'h1c00_0100 ^ MAGIC);
    check_eq("flush_second_pc", dpc[1], 32'h1c00_0104);

    // Redirect priority
    hold_reset();
    reset = 1'b0;
    #1;
    tick();
    excp_flush = 1'b1;
    excp_entry = 32'h1c00_8000;
    ertn_flush = 1'b1;
    era        = 32'h1c00_0040;
    flush      = 1'b1;
    flush_pc   = 32'h1c00_0100;
    tick();
    excp_flush = 1'b0;
    ertn_flush = 1'b0;
    flush      = 1'b0;
    #1;
    check_eq("prio_excp_addr", req_addr, 32'h1c00_8000);
    check_eq("prio_excp_resume", {31'h0, req_valid}, 32'd1);
    tick();
    ertn_flush = 1'b1;
    flush      = 1'b1;
    tick();
    ertn_flush = 1'b0;
    flush      = 1'b0;
    #1;
    check_eq("prio_ertn_addr", req_addr, 32'h1c00_0040);

    // Output backpressure, then stale responses drained under backpressure
    hold_reset();
    ib_ready = 1'b0;
    reset    = 1'b0;
    #1;
    repeat (5) tick();
    check_eq("bp_resp_ready", {31'h0, resp_ready}, 32'd0);
    check_eq("bp_ib_valid", {31'h0, ib_valid}, 32'd1);
    check_eq("bp_ib_pc", ib_pc, 32'h1c00_0000);
    check_eq("bp_ib_inst", ib_inst, 32'h1c00_0000 ^ MAGIC);
    flush    = 1'b1;
    flush_pc = 32'h1c00_0200;
    tick();
    flush = 1'b0;
    #1;
    check_eq("bp_flush_drop2", 32'(dut.drop_cnt_q), 32'd2);
    check_eq("bp_drop_resp_ready", {31'h0, resp_ready}, 32'd1);
    tick();
    check_eq("bp_flush_drop1", 32'(dut.drop_cnt_q), 32'd1);
    check_eq("bp_out_cnt1", 32'(dut.out_cnt_q), 32'd1);
    check_eq("bp_drop_ib_valid", {31'h0, ib_valid}, 32'd0);
    check_eq("bp_drop1_resp_ready", {31'h0, resp_ready}, 32'd1);
    ib_ready = 1'b1;

    // Response accepted in the flush cycle is itself dropped
    hold_reset();
    hold  = 1'b1;
    reset = 1'b0;
    drive_resp();
    #1;
    repeat (2) tick();
    check_eq("same_pre_out_cnt", 32'(dut.out_cnt_q), 32'd2);
    hold = 1'b0;
    drive_resp();
    flush    = 1'b1;
    flush_pc = 32'h1c00_0300;
    tick();
    flush = 1'b0;
    #1;
    check_eq("same_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    check_eq("same_out_cnt", 32'(dut.out_cnt_q), 32'd1);
    check_eq("same_ib_valid", {31'h0, ib_valid}, 32'd0);
    dpc.delete();
    dinst.delete();
    repeat (6) tick();
    check_eq("same_first_pc", dpc[0], 32'h1c00_0300);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
